// File: rtl/debounce_sync_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_sync_multi
// Description : Multi-channel input conditioner. Each channel passes an
//               asynchronous raw input through a SYNC_STAGES-deep flop chain,
//               then through a stability filter. The filter accepts a new
//               level only after it has been seen for L consecutive cycles,
//               where L = (i_db_limit == 0) ? 1 : i_db_limit. Each channel
//               also produces registered single-cycle rise and fall pulses.
//
// Parameters  : N_CH        number of independent channels (>= 1)
//               SYNC_STAGES synchroniser depth per channel (>= 2)
//               CNT_W       stability counter width, also width of i_db_limit
//               RST_VAL     reset value of sync chain and debounced level
//
// Ports       : clk         clock, all logic on the rising edge
//               rst_n       synchronous active-low reset
//               i_data      raw asynchronous inputs, one bit per channel
//               i_db_limit  required stable cycles; must come from the clk
//                           domain (it is not synchronised here)
//               o_level     debounced level per channel
//               o_rise      one-cycle pulse on a debounced 0->1 change
//               o_fall      one-cycle pulse on a debounced 1->0 change
//
// Optional    : macro DEBOUNCE_SYNC_IRQ_EN adds
//               i_irq_clr   write-1-to-clear per channel status
//               o_irq_stat  sticky per-channel status, set on any pulse
//               o_irq       OR of all status bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  i_data,
    input  logic [CNT_W-1:0] i_db_limit,
`ifdef DEBOUNCE_SYNC_IRQ_EN
    input  logic [N_CH-1:0]  i_irq_clr,
    output logic [N_CH-1:0]  o_irq_stat,
    output logic             o_irq,
`endif
    output logic [N_CH-1:0]  o_level,
    output logic [N_CH-1:0]  o_rise,
    output logic [N_CH-1:0]  o_fall
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Shared threshold. Comparing against L-1 lets the counter hold the
    // number of mismatching cycles already seen, so an update fires on the
    // L-th mismatching cycle. A limit of zero behaves like a limit of one.
    // Because the filter uses >=, lowering the limit while a channel is part
    // way through a count still produces an update on the next edge.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] w_limit_m1;

    assign w_limit_m1 = (i_db_limit == '0) ? '0 : (i_db_limit - c_cnt_one);

    // ------------------------------------------------------------------------
    // Per-channel datapath. Each channel keeps its own registers inside the
    // generate scope so no vector is written from more than one process.
    // ------------------------------------------------------------------------
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;

        logic                   w_s;
        logic                   w_diff;
        logic                   w_done;

        // Last stage of the synchroniser is the only point the filter reads.
        assign w_s    = r_sync[SYNC_STAGES-1];
        assign w_diff = w_s ^ r_level;
        // The counter can never exceed L-1 here: it is cleared whenever the
        // threshold is reached, so it cannot wrap for any legal limit.
        assign w_done = w_diff && (r_cnt >= w_limit_m1);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync  <= {SYNC_STAGES{RST_VAL}};
                r_cnt   <= '0;
                r_level <= RST_VAL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                // Plain shift chain, nothing between stages.
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_data[ch]};

                // Pulses are registered alongside the level so they appear in
                // exactly the cycle the new level is visible.
                r_rise <= w_done &  w_s;
                r_fall <= w_done & ~w_s;

                if (!w_diff) begin
                    // Input agrees with the accepted level: any partial count
                    // belonged to a glitch, so drop it.
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign o_level[ch] = r_level;
        assign o_rise[ch]  = r_rise;
        assign o_fall[ch]  = r_fall;

`ifdef DEBOUNCE_SYNC_IRQ_EN
        logic r_irq_stat;

        // Sticky event flag. The set term is OR-ed after the clear so an
        // event arriving in the same cycle as a clear is never lost.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_irq_stat <= 1'b0;
            end else begin
                r_irq_stat <= (r_irq_stat & ~i_irq_clr[ch]) | r_rise | r_fall;
            end
        end

        assign o_irq_stat[ch] = r_irq_stat;
`endif

    end : g_ch

`ifdef DEBOUNCE_SYNC_IRQ_EN
    assign o_irq = |o_irq_stat;
`endif

endmodule : debounce_sync_multi
`default_nettype wire

// File: doc/debounce_sync_multi.md
Name: debounce_sync_multi

Overview:
- Parametrised, multi-channel successor to the single-bit 2-FF synchroniser/edge-pulse block.
- Each channel of asynchronous input is synchronised through a configurable-depth flop chain, then filtered by a run-time-programmable stability counter.
- Each channel outputs a debounced level plus single-cycle rise and fall pulses.
- Sits between board-level inputs (buttons, straps, slow status lines) and control logic in the clk domain.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
- CNT_W, 16, width of stability counter and of i_db_limit
- RST_VAL, 1'b0, reset value of sync chain and debounced level, applied to all channels

Ports:
- clk  input  1  clock; all logic on posedge
- rst_n  input  1  reset, synchronous, active-low
- i_data  input  N_CH  asynchronous raw inputs, one bit per channel
- i_db_limit  input  CNT_W  required consecutive stable cycles; quasi-static, shared by all channels
- o_level  output  N_CH  debounced level per channel
- o_rise  output  N_CH  1-cycle pulse on debounced 0->1
- o_fall  output  N_CH  1-cycle pulse on debounced 1->0

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n sampled on posedge clk only. No asynchronous path.
- Reset values:
  - Sync chain = RST_VAL; o_level = RST_VAL; o_rise = 0; o_fall = 0; counters = 0.
- Synchroniser:
  - Per channel, SYNC_STAGES-deep shift chain. s[ch] is the last stage.
  - No logic between stages.
- Effective limit:
  - L = (i_db_limit == 0) ? 1 : i_db_limit.
- Per-channel filter, evaluated each posedge:
  - s == o_level: cnt <= 0. No level change.
  - s != o_level and cnt >= L-1: o_level <= s; cnt <= 0.
  - s != o_level and cnt < L-1: cnt <= cnt + 1.
  - Counter never wraps. The >= compare guarantees an update even if i_db_limit is lowered mid-count.
  - A glitch shorter than L cycles (as seen at s) resets cnt and leaves o_level unchanged.
- Edge pulses:
  - Registered; asserted in exactly the cycle o_level changes.
  - o_rise = 1 for o_level 0->1; o_fall = 1 for 1->0.
  - Both deassert the next cycle unless a new change occurs (impossible within L >= 1 cycles).
  - o_rise and o_fall are never high together on one channel.
- Latency:
  - Raw input step held stable: o_level changes SYNC_STAGES + L edges after the first sampling edge.
  - Example: SYNC_STAGES=2, L=4 gives 6 edges.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-operation: all state returns to reset values on the next edge. No pulses are generated by reset itself.
- i_db_limit is not synchronised internally. It must come from the clk domain.

Optional Feature:
- Macro: DEBOUNCE_SYNC_IRQ_EN.
- When defined, the block adds:
  - Input i_irq_clr [N_CH]: write-1-to-clear.
  - Output o_irq_stat [N_CH]: sticky status.
  - Output o_irq [1]: combinational OR of o_irq_stat.
- o_irq_stat[ch] rules:
  - Set on o_rise[ch] | o_fall[ch].
  - Cleared by i_irq_clr[ch]=1.
  - Set wins when set and clear hit the same cycle.
  - Reset value 0.
- When undefined: those ports and registers do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset check:
  - Stimulus: hold rst_n=0 for 3 cycles with i_data=4'hF.
  - Required: o_level=4'h0 (RST_VAL=0), o_rise=o_fall=0 throughout, and no pulses on the first cycle after release.
- Clean step:
  - Stimulus: SYNC_STAGES=2, i_db_limit=4, ch0 0->1 held.
  - Required: o_level[0] rises 6 edges after the first sampling edge, o_rise[0] high exactly that one cycle, o_fall stays 0.
- Glitch rejection:
  - Stimulus: i_db_limit=4; ch1 high for 3 cycles, then low.
  - Required: o_level[1] stays 0; no rise or fall pulse.
  - Then hold ch1 high for 4 cycles: o_level[1] goes to 1.
- Limit boundary and independence:
  - Stimulus: i_db_limit=0; ch2 toggles every 5 cycles while ch3 toggles simultaneously.
  - Required: each output follows its input SYNC_STAGES+1 edges later, with one pulse per transition per channel.
  - Lower i_db_limit from 100 to 2 while ch0 cnt=50: o_level[0] updates on the next edge.
- Mid-operation reset:
  - Stimulus: i_db_limit=8; ch0 high for 5 cycles, then rst_n=0 for 1 cycle while ch0 stays high.
  - Required: counter restarts from 0; o_level[0] rises 2+8 edges after reset release.
- IRQ feature (with DEBOUNCE_SYNC_IRQ_EN):
  - Rise on ch1: o_irq_stat=4'h2 and o_irq=1.
  - Assert i_irq_clr=4'h2 in the same cycle as a new fall pulse on ch1: stat stays 1 (set wins).
  - Clear again alone: stat returns to 0 and o_irq=0.
